// File: rtl/core_pkg.sv
// Shared definitions for the multi-cycle RV32I core: opcodes, datapath
// select encodings, the control FSM state set and the immediate decode.
package core_pkg;

    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    // Must stay in step with the ALU control decoder.
    typedef enum logic [1:0] {
        ALUOP_ADD    = 2'b00,
        ALUOP_BRANCH = 2'b01,
        ALUOP_RTYPE  = 2'b10,
        ALUOP_ITYPE  = 2'b11
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_src_e;

    typedef enum logic [1:0] {
        RES_ALUOUT    = 2'b00,
        RES_DATA      = 2'b01,
        RES_ALURESULT = 2'b10,
        RES_IMM       = 2'b11
    } result_src_e;

    typedef enum logic [1:0] {
        SRCA_PC    = 2'b00,
        SRCA_OLDPC = 2'b01,
        SRCA_REGA  = 2'b10
    } alu_src_a_e;

    typedef enum logic [1:0] {
        SRCB_REGB = 2'b00,
        SRCB_IMM  = 2'b01,
        SRCB_FOUR = 2'b10
    } alu_src_b_e;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JALR, S_JAL, S_LUI, S_ERROR
    } state_e;

    // Immediate format implied by the opcode; unknown opcodes fall back to I.
    function automatic imm_src_e imm_src_of(input logic [6:0] op);
        case (op)
            OP_LW, OP_I, OP_JALR: return IMM_I;
            OP_SW:                return IMM_S;
            OP_BRANCH:            return IMM_B;
            OP_JAL:               return IMM_J;
            OP_LUI:               return IMM_U;
            default:              return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: decode inputs and all control outputs.
interface multicycle_controller_if;
    logic [6:0] op;
    logic       alu_zero;
    logic       mem_ready;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [2:0] imm_src;
    logic       reg_write;
    logic       instr_done;
    logic       illegal_instr;

    // Datapath side: supplies status, consumes controls.
    modport master (
        output op, alu_zero, mem_ready,
        input  pc_write, adr_src, mem_write, ir_write, result_src,
               alu_src_a, alu_src_b, alu_op, imm_src, reg_write,
               instr_done, illegal_instr
    );

    // Controller side.
    modport slave (
        input  op, alu_zero, mem_ready,
        output pc_write, adr_src, mem_write, ir_write, result_src,
               alu_src_a, alu_src_b, alu_op, imm_src, reg_write,
               instr_done, illegal_instr
    );
endinterface

// File: rtl/multicycle_controller.sv
// Main control FSM of the multi-cycle RV32I core with a memory watchdog.
module multicycle_controller
    import core_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    multicycle_controller_if.slave  bus
);

    // Counter only ever needs to hold MEM_TIMEOUT-1.
    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_e           state_reg, state_next;
    logic [CNT_W-1:0] wdog_reg, wdog_next;

    logic        waiting, timeout;
    logic        pc_write_raw, ir_write_raw, mem_write_raw;
    logic        reg_write_raw, instr_done_raw;
    logic        adr_src, illegal;
    result_src_e result_src;
    alu_src_a_e  alu_src_a;
    alu_src_b_e  alu_src_b;
    alu_op_e     alu_op;

    assign waiting = ((state_reg == S_FETCH) || (state_reg == S_MEMREAD) ||
                      (state_reg == S_MEMWRITE)) && !bus.mem_ready;
    assign timeout = (MEM_TIMEOUT != 0) && waiting && (wdog_reg == WDOG_LAST);

    // State and watchdog registers; reset aborts any instruction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_FETCH;
            wdog_reg  <= '0;
        end else begin
            state_reg <= state_next;
            wdog_reg  <= wdog_next;
        end
    end

    // Watchdog counts stalled memory cycles and restarts on every state change.
    always_comb begin
        wdog_next = wdog_reg;
        if (state_next != state_reg)
            wdog_next = '0;
        else if (waiting && (MEM_TIMEOUT != 0))
            wdog_next = wdog_reg + 1'b1;
    end

    // Next-state and Moore output decode; a watchdog expiry overrides the step.
    always_comb begin
        state_next     = state_reg;
        pc_write_raw   = 1'b0;
        ir_write_raw   = 1'b0;
        mem_write_raw  = 1'b0;
        reg_write_raw  = 1'b0;
        instr_done_raw = 1'b0;
        adr_src        = 1'b0;
        illegal        = 1'b0;
        result_src     = RES_ALUOUT;
        alu_src_a      = SRCA_PC;
        alu_src_b      = SRCB_REGB;
        alu_op         = ALUOP_ADD;
        case (state_reg)
            S_FETCH: begin
                alu_src_b    = SRCB_FOUR;
                result_src   = RES_ALURESULT;
                pc_write_raw = bus.mem_ready;
                ir_write_raw = bus.mem_ready;
                if (bus.mem_ready) state_next = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                case (bus.op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_R:         state_next = S_EXECR;
                    OP_I:         state_next = S_EXECI;
                    OP_BRANCH:    state_next = S_BRANCH;
                    OP_JAL:       state_next = S_JAL;
                    OP_JALR:      state_next = S_JALR;
                    OP_LUI:       state_next = S_LUI;
                    default:      state_next = S_ERROR;
                endcase
            end
            S_MEMADR: begin
                alu_src_a  = SRCA_REGA;
                alu_src_b  = SRCB_IMM;
                state_next = (bus.op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                if (bus.mem_ready) state_next = S_MEMWB;
            end
            S_MEMWB: begin
                result_src     = RES_DATA;
                reg_write_raw  = 1'b1;
                instr_done_raw = 1'b1;
                state_next     = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src        = 1'b1;
                mem_write_raw  = 1'b1;
                instr_done_raw = bus.mem_ready;
                if (bus.mem_ready) state_next = S_FETCH;
            end
            S_EXECR: begin
                alu_src_a  = SRCA_REGA;
                alu_op     = ALUOP_RTYPE;
                state_next = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a  = SRCA_REGA;
                alu_src_b  = SRCB_IMM;
                alu_op     = ALUOP_ITYPE;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_raw  = 1'b1;
                instr_done_raw = 1'b1;
                state_next     = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a      = SRCA_REGA;
                alu_op         = ALUOP_BRANCH;
                pc_write_raw   = bus.alu_zero;
                instr_done_raw = 1'b1;
                state_next     = S_FETCH;
            end
            S_JALR: begin
                alu_src_a  = SRCA_REGA;
                alu_src_b  = SRCB_IMM;
                state_next = S_JAL;
            end
            S_JAL: begin
                // PC takes the target; ALU forms OldPC+4 for the link write.
                alu_src_a    = SRCA_OLDPC;
                alu_src_b    = SRCB_FOUR;
                pc_write_raw = 1'b1;
                state_next   = S_ALUWB;
            end
            S_LUI: begin
                result_src     = RES_IMM;
                reg_write_raw  = 1'b1;
                instr_done_raw = 1'b1;
                state_next     = S_FETCH;
            end
            S_ERROR: illegal = 1'b1;
            default: state_next = S_ERROR;
        endcase
        if (timeout) state_next = S_ERROR;
    end

    // Enables are masked by reset so nothing can write while rst_n is low.
    assign bus.pc_write      = pc_write_raw   & rst_n;
    assign bus.ir_write      = ir_write_raw   & rst_n;
    assign bus.mem_write     = mem_write_raw  & rst_n;
    assign bus.reg_write     = reg_write_raw  & rst_n;
    assign bus.instr_done    = instr_done_raw & rst_n;
    assign bus.adr_src       = adr_src;
    assign bus.result_src    = result_src;
    assign bus.alu_src_a     = alu_src_a;
    assign bus.alu_src_b     = alu_src_b;
    assign bus.alu_op        = alu_op;
    assign bus.illegal_instr = illegal;
    assign bus.imm_src       = imm_src_of(bus.op);

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: each instruction is modelled as a script of cycle
// records built from its opcode; random stimulus is checked every cycle.
module tb_multicycle_controller;

    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multicycle_controller_if bus ();

    multicycle_controller #(.MEM_TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // One cycle of an instruction. pcw_mode: 0 off, 1 = mem_ready (also IR),
    // 2 = alu_zero, 3 = on. done_mode: 0 off, 1 on, 2 = mem_ready.
    typedef struct {
        logic       adr;
        logic [1:0] rs, a, b, aop;
        logic       mw, rw;
        int         done_mode;
        int         pcw_mode;
        bit         waits;
    } step_t;

    step_t      script[$];
    logic [6:0] op_q[$];
    logic [6:0] cur_op;
    int         pos, wait_cnt, instr_cycles;
    bit         ends_err, in_error, need_instr;
    int         tests = 0;
    int         fails = 0;

    logic [6:0] legal_ops [8] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                                  7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111};

    logic       snap_pcw, snap_adr, snap_mw, snap_irw, snap_rw, snap_done, snap_ill;
    logic [1:0] snap_rs, snap_a, snap_b, snap_aop;
    logic [2:0] snap_imm;

    function automatic step_t mk(input logic adr, input logic [1:0] rs, input logic [1:0] a,
                                 input logic [1:0] b, input logic [1:0] aop, input logic mw,
                                 input logic rw, input int done_mode, input int pcw_mode,
                                 input bit waits);
        step_t s;
        s.adr = adr; s.rs = rs; s.a = a; s.b = b; s.aop = aop;
        s.mw = mw; s.rw = rw; s.done_mode = done_mode; s.pcw_mode = pcw_mode; s.waits = waits;
        return s;
    endfunction

    function automatic step_t fetch_step();
        return mk(1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0, 0, 1, 1'b1);
    endfunction

    function automatic step_t aluwb_step();
        return mk(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1, 0, 1'b0);
    endfunction

    function automatic void build(input logic [6:0] op);
        step_t memadr;
        memadr = mk(1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0, 1'b0, 0, 0, 1'b0);
        script.delete();
        ends_err = 1'b0;
        script.push_back(fetch_step());
        script.push_back(mk(1'b0, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 0, 0, 1'b0));
        case (op)
            7'b0000011: begin
                script.push_back(memadr);
                script.push_back(mk(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 0, 0, 1'b1));
                script.push_back(mk(1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1, 0, 1'b0));
            end
            7'b0100011: begin
                script.push_back(memadr);
                script.push_back(mk(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 2, 0, 1'b1));
            end
            7'b0110011: begin
                script.push_back(mk(1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0, 1'b0, 0, 0, 1'b0));
                script.push_back(aluwb_step());
            end
            7'b0010011: begin
                script.push_back(mk(1'b0, 2'b00, 2'b10, 2'b01, 2'b11, 1'b0, 1'b0, 0, 0, 1'b0));
                script.push_back(aluwb_step());
            end
            7'b1100011:
                script.push_back(mk(1'b0, 2'b00, 2'b10, 2'b00, 2'b01, 1'b0, 1'b0, 1, 2, 1'b0));
            7'b1100111: begin
                script.push_back(mk(1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0, 1'b0, 0, 0, 1'b0));
                script.push_back(mk(1'b0, 2'b00, 2'b01, 2'b10, 2'b00, 1'b0, 1'b0, 0, 3, 1'b0));
                script.push_back(aluwb_step());
            end
            7'b1101111: begin
                script.push_back(mk(1'b0, 2'b00, 2'b01, 2'b10, 2'b00, 1'b0, 1'b0, 0, 3, 1'b0));
                script.push_back(aluwb_step());
            end
            7'b0110111:
                script.push_back(mk(1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1, 0, 1'b0));
            default: ends_err = 1'b1;
        endcase
    endfunction

    function automatic logic [2:0] imm_exp(input logic [6:0] op);
        case (op)
            7'b0000011, 7'b0010011, 7'b1100111: return 3'b000;
            7'b0100011: return 3'b001;
            7'b1100011: return 3'b010;
            7'b1101111: return 3'b011;
            7'b0110111: return 3'b100;
            default:    return 3'b000;
        endcase
    endfunction

    function automatic void start_instr();
        if (op_q.size() > 0)
            cur_op = op_q.pop_front();
        else if ($urandom_range(0, 19) == 0)
            cur_op = 7'($urandom);
        else
            cur_op = legal_ops[$urandom_range(0, 7)];
        build(cur_op);
        pos = 0;
        wait_cnt = 0;
        instr_cycles = 0;
        need_instr = 1'b0;
    endfunction

    function automatic void model_reset();
        in_error = 1'b0;
        need_instr = 1'b1;
        wait_cnt = 0;
        pos = 0;
    endfunction

    // Outputs required this cycle, packed in the same order as dut_vec().
    function automatic logic [17:0] expect_vec(input logic mr, input logic az);
        step_t s;
        logic pcw, irw, done;
        logic [2:0] imm;
        imm = imm_exp(cur_op);
        if (!rst_n) begin
            s = fetch_step();
            return {1'b0, s.adr, 1'b0, 1'b0, s.rs, s.a, s.b, s.aop, imm, 1'b0, 1'b0, 1'b0};
        end
        if (in_error)
            return {10'b0, 2'b00, 3'b000 | imm, 1'b0, 1'b0, 1'b1};
        s = script[pos];
        pcw  = (s.pcw_mode == 1) ? mr : (s.pcw_mode == 2) ? az : (s.pcw_mode == 3);
        irw  = (s.pcw_mode == 1) ? mr : 1'b0;
        done = (s.done_mode == 2) ? mr : (s.done_mode == 1);
        return {pcw, s.adr, s.mw, irw, s.rs, s.a, s.b, s.aop, imm, s.rw, done, 1'b0};
    endfunction

    function automatic logic [17:0] dut_vec();
        return {bus.pc_write, bus.adr_src, bus.mem_write, bus.ir_write, bus.result_src,
                bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.imm_src, bus.reg_write,
                bus.instr_done, bus.illegal_instr};
    endfunction

    function automatic void model_advance(input logic mr);
        if (in_error) return;
        instr_cycles++;
        if (script[pos].waits && !mr) begin
            wait_cnt++;
            if (wait_cnt >= TIMEOUT) in_error = 1'b1;
        end else begin
            wait_cnt = 0;
            pos++;
            if (pos >= script.size()) begin
                if (ends_err) in_error = 1'b1;
                else need_instr = 1'b1;
                $display("[TB] instr op=%b cycles=%0d%s", cur_op, instr_cycles,
                         ends_err ? " trapped" : "");
            end
        end
        if (in_error && !ends_err)
            $display("[TB] instr op=%b watchdog trap after %0d cycles", cur_op, instr_cycles);
    endfunction

    task automatic compare_now();
        logic [17:0] exp_v, got_v;
        exp_v = expect_vec(bus.mem_ready, bus.alu_zero);
        got_v = dut_vec();
        tests++;
        if (got_v !== exp_v) begin
            fails++;
            $display("[TB] FAIL cycle_compare t=%0t op=%b got=%b expected=%b",
                     $time, cur_op, got_v, exp_v);
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // One clock: drive inputs, check at negedge, advance model at posedge.
    task automatic step(input logic mr, input logic az);
        if (need_instr && !in_error) start_instr();
        bus.op = cur_op;
        bus.mem_ready = mr;
        bus.alu_zero = az;
        @(negedge clk);
        compare_now();
        snap_pcw = bus.pc_write;   snap_adr = bus.adr_src;   snap_mw = bus.mem_write;
        snap_irw = bus.ir_write;   snap_rw = bus.reg_write;  snap_done = bus.instr_done;
        snap_ill = bus.illegal_instr; snap_rs = bus.result_src; snap_a = bus.alu_src_a;
        snap_b = bus.alu_src_b;    snap_aop = bus.alu_op;    snap_imm = bus.imm_src;
        @(posedge clk);
        model_advance(mr);
        #1;
    endtask

    task automatic reset_pulse();
        bus.mem_ready = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        compare_now();
        check("rst_illegal_clear", 32'(bus.illegal_instr), 32'd0);
        check("rst_pc_write_forced", 32'(bus.pc_write), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int cnt, cnt2, err_cycles;
        cur_op = 7'b0110011;
        bus.op = cur_op;
        bus.alu_zero = 1'b0;
        bus.mem_ready = 1'b1;
        model_reset();
        reset_pulse();

        // R-type add: 4 cycles, ALUOp 10 in EXECR, writeback in cycle 4.
        op_q.push_back(7'b0110011);
        cnt = 0;
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 1'b0);
            cnt += int'(snap_done);
            if (i == 3) check("r_execr_aluop", 32'(snap_aop), 32'd2);
            if (i == 4) check("r_aluwb_rw_done", 32'({snap_rw, snap_done}), 32'd3);
        end
        check("r_done_pulses", 32'(cnt), 32'd1);

        // lw with three stalled MEMREAD cycles: 8 cycles total.
        op_q.push_back(7'b0000011);
        cnt = 0;
        for (int i = 1; i <= 8; i++) begin
            step((i >= 4 && i <= 6) ? 1'b0 : 1'b1, 1'b0);
            cnt += int'(snap_adr);
            if (i == 8) check("lw_memwb", 32'({snap_rs, snap_rw, snap_done}), 32'b0111);
        end
        check("lw_memread_cycles", 32'(cnt), 32'd4);

        // Branch taken then not taken.
        op_q.push_back(7'b1100011);
        op_q.push_back(7'b1100011);
        for (int i = 1; i <= 3; i++) step(1'b1, 1'b1);
        check("br_taken", 32'({snap_pcw, snap_aop, snap_imm, snap_done}), 32'b1_01_010_1);
        for (int i = 1; i <= 3; i++) step(1'b1, 1'b0);
        check("br_not_taken", 32'({snap_pcw, snap_done}), 32'b01);

        // jalr: DECODE, JALR, JAL, ALUWB.
        op_q.push_back(7'b1100111);
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, 1'b0);
            if (i == 4) check("jal_stage", 32'({snap_pcw, snap_rs, snap_a, snap_b}), 32'b1_00_01_10);
            if (i == 5) check("jalr_aluwb_rw", 32'(snap_rw), 32'd1);
        end

        // Illegal opcode traps and stays trapped regardless of mem_ready.
        op_q.push_back(7'b1111111);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        cnt = 0;
        cnt2 = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'(i % 2), 1'b1);
            cnt += int'(snap_ill);
            cnt2 += int'(snap_pcw | snap_irw | snap_rw | snap_mw);
        end
        check("illegal_sticky", 32'(cnt), 32'd6);
        check("illegal_no_enables", 32'(cnt2), 32'd0);
        reset_pulse();
        op_q.push_back(7'b0110111);
        step(1'b1, 1'b0);
        check("fetch_after_rst", 32'({snap_pcw, snap_irw, snap_ill}), 32'b110);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        check("lui_wb", 32'({snap_rs, snap_rw, snap_imm}), 32'b11_1_100);

        // sw with mem_ready stuck low: 16 strobe cycles, then trap.
        op_q.push_back(7'b0100011);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b0);
            cnt += int'(snap_mw);
        end
        check("timeout_mw_cycles", 32'(cnt), 32'd16);
        step(1'b0, 1'b0);
        check("timeout_error", 32'({snap_ill, snap_mw}), 32'b10);
        reset_pulse();

        // Reset dropped mid-MEMWRITE pulls mem_write low without a clock.
        op_q.push_back(7'b0100011);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        bus.mem_ready = 1'b0;
        @(negedge clk);
        compare_now();
        #2;
        check("async_mw_before", 32'(bus.mem_write), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_mw_drop", 32'(bus.mem_write), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();

        // Random instruction stream with random memory stalls and branch flags.
        err_cycles = 0;
        for (int c = 0; c < 3000; c++) begin
            if (in_error) begin
                err_cycles++;
                if (err_cycles > 3) begin
                    reset_pulse();
                    err_cycles = 0;
                end
            end
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
